game_core: RTL

GAME_CORE -- requirements
Module: game_core

---
 rtl/game_core.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/game_core.sv
// game_core: IDLE/RUN/OVER game controller with tick-paced parabolic jump,
//            a survival score and a per-channel obstacle collision check.
// Latency: a collision or start button registers the state change on the next
//          clk edge. There is no backpressure: the inputs are sampled every cycle.
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   up                 jump/start button (synchronous, edge-detected inside)
//   obst_pos           N_OBST packed obstacle positions, channel i at [i*POS_W +: POS_W]
//   obst_sync          positions are being updated; collision is suppressed
//   jump_h             registered player height
//   game_over/running  state flags (game_over in IDLE and OVER, running in RUN)
//   score              ticks survived in the current run, saturating
//   hit_idx            lowest colliding channel, captured on entry to OVER
module game_core #(
  parameter int N_OBST   = 4,
  parameter int POS_W    = 12,
  parameter int H_W      = 9,
  parameter int TICK_DIV = 1562500,
  parameter int JUMP_LEN = 14,
  parameter int CLEAR_H  = 32,
  parameter int SCREEN_W = 1024,
  parameter int HIT_LO   = 200,
  parameter int HIT_HI   = 300,
  parameter int OBST_W   = 50,
  localparam int HIT_W   = (N_OBST > 1) ? $clog2(N_OBST) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    up,
  input  logic [N_OBST*POS_W-1:0] obst_pos,
  input  logic                    obst_sync,
  output logic [H_W-1:0]          jump_h,
  output logic                    game_over,
  output logic                    running,
  output logic [15:0]             score,
  output logic [HIT_W-1:0]        hit_idx
);

  localparam int TC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int K_W  = $clog2(2*JUMP_LEN + 1);
  localparam int SW   = 2*H_W + 1;
  localparam int DW   = POS_W + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             up_q;
  logic [TC_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [K_W-1:0]   k_q, k_d;
  logic             jump_act_q, jump_act_d;
  logic [H_W-1:0]   jump_h_q, jump_h_d;
  logic [15:0]      score_q, score_d;
  logic [HIT_W-1:0] hit_idx_q, hit_idx_d;

  logic             up_rise;
  logic             in_run;
  logic             tick;
  logic [K_W-1:0]   k_inc;
  logic             jump_end;
  logic signed [SW-1:0] diff;
  logic signed [SW-1:0] sq;
  logic signed [SW-1:0] h_full;
  logic             unused_h;
  logic             invuln;
  logic             hit_any;
  logic [HIT_W-1:0] hit_lo_idx;
  logic [POS_W-1:0] ch_pos;
  logic signed [DW-1:0] ch_d;
  logic             collision;

  assign up_rise = up & ~up_q;
  assign in_run  = (state_q == S_RUN);
  assign tick    = in_run && (tick_cnt_q == TC_W'(TICK_DIV - 1));

  // Height for the next jump step: JUMP_LEN^2 - (k-JUMP_LEN)^2, evaluated
  // signed and wide enough that the square never overflows.
  assign k_inc    = k_q + K_W'(1);
  assign jump_end = (k_inc == K_W'(2*JUMP_LEN));
  assign diff     = $signed(SW'(k_inc)) - SW'(JUMP_LEN);
  assign sq       = diff * diff;
  assign h_full   = SW'(JUMP_LEN*JUMP_LEN) - sq;
  // The result is never negative and never exceeds JUMP_LEN^2, so the
  // upper bits carry no information.
  assign unused_h = ^h_full[SW-1:H_W];

  assign invuln = (jump_h_q >= H_W'(CLEAR_H));

  // Obstacle window test. The downward scan leaves the lowest hitting
  // channel in hit_lo_idx. A negative distance means the obstacle has not
  // entered the screen yet.
  always_comb begin
    hit_any    = 1'b0;
    hit_lo_idx = '0;
    ch_pos     = '0;
    ch_d       = '0;
    for (int i = N_OBST - 1; i >= 0; i--) begin
      ch_pos = obst_pos[i*POS_W +: POS_W];
      ch_d   = DW'(SCREEN_W) - $signed({2'b00, ch_pos});
      if (!ch_d[DW-1] && (ch_d <= DW'(HIT_HI)) &&
          ((ch_d + DW'(OBST_W)) >= DW'(HIT_LO))) begin
        hit_any    = 1'b1;
        hit_lo_idx = HIT_W'(i);
      end
    end
  end

  assign collision = in_run & ~obst_sync & ~invuln & hit_any;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    k_d        = k_q;
    jump_act_d = jump_act_q;
    jump_h_d   = jump_h_q;
    score_d    = score_q;
    hit_idx_d  = hit_idx_q;
    case (state_q)
      S_IDLE: begin
        tick_cnt_d = '0;
        if (up_rise) begin
          state_d    = S_RUN;
          jump_act_d = 1'b1;
          k_d        = '0;
          jump_h_d   = '0;
          score_d    = '0;
        end
      end
      S_RUN: begin
        if (collision) begin
          // Collision takes priority over any start press.
          // Everything else freezes.
          state_d   = S_OVER;
          hit_idx_d = hit_lo_idx;
        end else begin
          tick_cnt_d = tick ? '0 : tick_cnt_q + TC_W'(1);
          if (tick && (score_q != 16'hFFFF)) begin
            score_d = score_q + 16'd1;
          end
          if (up_rise && !jump_act_q) begin
            // The tick phase restarts so every jump step is a full tick long.
            jump_act_d = 1'b1;
            k_d        = '0;
            jump_h_d   = '0;
            tick_cnt_d = '0;
          end else if (jump_act_q && tick) begin
            if (jump_end) begin
              jump_act_d = 1'b0;
              k_d        = '0;
              jump_h_d   = '0;
            end else begin
              k_d      = k_inc;
              jump_h_d = h_full[H_W-1:0];
            end
          end
        end
      end
      S_OVER: begin
        if (up_rise) begin
          state_d    = S_IDLE;
          jump_act_d = 1'b0;
          k_d        = '0;
          jump_h_d   = '0;
          tick_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      up_q       <= 1'b0;
      tick_cnt_q <= '0;
      k_q        <= '0;
      jump_act_q <= 1'b0;
      jump_h_q   <= '0;
      score_q    <= '0;
      hit_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      up_q       <= up;
      tick_cnt_q <= tick_cnt_d;
      k_q        <= k_d;
      jump_act_q <= jump_act_d;
      jump_h_q   <= jump_h_d;
      score_q    <= score_d;
      hit_idx_q  <= hit_idx_d;
    end
  end

  assign jump_h    = jump_h_q;
  assign game_over = (state_q != S_RUN);
  assign running   = (state_q == S_RUN);
  assign score     = score_q;
  assign hit_idx   = hit_idx_q;

endmodule
